// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a cascade of 74HC595 shift registers: shifts a DATA_W-bit frame, latches it, pulses done.
// Optional macro HC595_PWM_EN adds a brightness input that dims the chain through oe.
module hc595_chain_ctrl #(
  parameter int DATA_W    = 14,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
`ifdef HC595_PWM_EN
  input  logic [7:0]        brightness,
`endif
  output logic              data_ready,
  output logic              ds,
  output logic              shcp,
  output logic              stcp,
  output logic              oe,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div, div_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              en, en_nxt;
  logic              handshake, div_end, last_bit;
  logic              ds_nxt, shcp_nxt, stcp_nxt, oe_nxt, busy_nxt, done_nxt, ready_nxt;

`ifdef HC595_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) pwm_cnt <= 8'd0;
    else         pwm_cnt <= pwm_cnt + 8'd1;
  end
`endif

  assign handshake = data_valid & data_ready;
  assign div_end   = (div == DIV_LAST);
  assign last_bit  = (bit_cnt == CNT_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      en      <= 1'b0;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      en      <= en_nxt;
    end
  end

  // The bit currently on ds always sits at the outgoing end of shreg; the last bit is held through LATCH.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nxt   = SHIFT;
          div_nxt     = '0;
          bit_cnt_nxt = '0;
          shreg_nxt   = data_in;
        end
      end
      SHIFT: begin
        if (div_end) begin
          div_nxt = '0;
          if (last_bit) begin
            state_nxt = LATCH;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            shreg_nxt   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_end) begin
          div_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ds_nxt    = (MSB_FIRST != 0) ? shreg_nxt[DATA_W-1] : shreg_nxt[0];
    shcp_nxt  = (state_nxt == SHIFT) && (div_nxt >= DIV_HALF);
    stcp_nxt  = (state_nxt == LATCH) && (div_nxt >= DIV_HALF);
    busy_nxt  = (state_nxt != IDLE);
    ready_nxt = (state_nxt == IDLE);
    done_nxt  = (state == LATCH) && (state_nxt == IDLE);
    en_nxt    = en | done;
`ifdef HC595_PWM_EN
    oe_nxt    = en_nxt ? (pwm_cnt >= brightness) : 1'b1;
`else
    oe_nxt    = ~en_nxt;
`endif
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ds         <= 1'b0;
      shcp       <= 1'b0;
      stcp       <= 1'b0;
      oe         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_ready <= 1'b1;
    end else begin
      ds         <= ds_nxt;
      shcp       <= shcp_nxt;
      stcp       <= stcp_nxt;
      oe         <= oe_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      data_ready <= ready_nxt;
    end
  end

endmodule

// File: doc/hc595_chain_ctrl.md
Name: hc595_chain_ctrl

Overview:
- Parametrised serial driver for a cascade of 74HC595 shift registers.
- Serves as the successor to the fixed 14-bit segment/digit-select driver.
- Accepts a DATA_W-bit parallel word through a valid/ready handshake and shifts it out MSB- or LSB-first at a programmable SHCP rate.
- Pulses STCP to latch the word, then reports completion.
- Sits between the display/IO scan logic and the board-level 595 chain.

Parameters:
- DATA_W, 14: bits per frame (total chain length); range 1..64.
- CLK_DIV, 4: sys_clk cycles per shifted bit; even, >=2.
- MSB_FIRST, 1: 1 = data_in[DATA_W-1] shifted first; 0 = data_in[0] shifted first.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  asynchronous reset, active-high.
- data_in  in  DATA_W  frame to transmit; sampled only on handshake.
- data_valid  in  1  frame request.
- data_ready  out  1  high in IDLE; handshake = data_valid & data_ready at a rising edge.
- ds  out  1  serial data to the 595 chain.
- shcp  out  1  shift clock.
- stcp  out  1  storage/latch clock.
- oe  out  1  595 output enable, active-low.
- busy  out  1  high in SHIFT or LATCH.
- done  out  1  one-cycle pulse when a frame has been latched.

Behaviour:
- Reset values: ds=0, shcp=0, stcp=0, oe=1, busy=0, done=0, data_ready=1. FSM goes to IDLE; the bit counter and divider are cleared. All outputs are registered.
- FSM states: IDLE -> SHIFT on handshake; SHIFT -> LATCH after the last bit window; LATCH -> IDLE after CLK_DIV cycles.
- Handshake: at edge E0, data_in is copied into the shadow register. data_ready drops and busy rises in cycle E0+1.
- Ready rule: data_ready is low throughout SHIFT and LATCH, so data_valid is ignored there.
- Divider: div counts 0..CLK_DIV-1 and restarts at 0 in the first cycle of each bit window and of the latch window.
- Bit k timing: bit k (k = 0..DATA_W-1) occupies cycles E0+1+k*CLK_DIV through E0+(k+1)*CLK_DIV.
  - ds holds bit k for the whole window.
  - shcp is high for the last CLK_DIV/2 cycles of the window, so the rising edge occurs mid-window with ds stable.
- Bit order: MSB_FIRST=1 sends data_in[DATA_W-1] first. MSB_FIRST=0 sends data_in[0] first.
- LATCH window: CLK_DIV cycles, starting at E0+1+DATA_W*CLK_DIV. shcp=0 throughout. stcp is high for the last CLK_DIV/2 cycles. ds holds the last bit.
- Frame completion: in cycle E0+1+(DATA_W+1)*CLK_DIV the FSM is in IDLE, done=1 for exactly one cycle, data_ready=1 and busy=0. A handshake may occur in this same cycle, giving back-to-back frames with no extra gap.
- oe enable: oe stays 1 after reset until the first done. From then on oe=0, which blanks the chain's undefined power-up contents.
- Reset mid-frame: everything returns to reset values immediately. shcp and stcp fall to 0 asynchronously. oe returns to 1. No done pulse is generated for the aborted frame.
- Change-while-busy: changes on data_in while busy have no effect on the current frame.

Optional Feature:
- Macro: HC595_PWM_EN.
- When defined:
  - A brightness[7:0] input port is added.
  - A free-running 8-bit pwm counter is reset to 0 by sys_rst.
  - oe = 1 while not yet enabled; after enable, oe = (pwm_cnt >= brightness).
  - Effect: brightness 0 gives fully dark, and brightness B gives oe low for B out of every 256 cycles.
  - brightness is sampled every cycle; no glitch protection is required.
- When undefined: no port, no counter; oe behaves exactly as described above.

Test Plan:
- Defaults (DATA_W=14, CLK_DIV=4, MSB_FIRST=1): handshake 14'h2A5B at E0.
  - ds sampled on the 14 shcp rising edges reads 1,0,1,0,1,0,0,1,0,1,1,0,1,1.
  - stcp is high exactly in cycles E0+59 and E0+60.
  - done is high only in E0+61; oe falls at E0+62.
- MSB_FIRST=0, same word: the captured ds sequence is bit-reversed (first bit 1, then 1, 0, 1, 1, 0, ...). Frame timing is identical.
- Back-to-back: data_valid held high with 14'h3FFF then 14'h0000. The second handshake lands in the done cycle (E0+61). The second frame's shcp edges start at E0+64 and no cycles are lost.
- Ignore while busy: data_valid pulsed with 14'h1234 at E0+20 during a frame. There is no effect; exactly 14 shcp edges and one stcp pulse occur per accepted frame.
- Reset mid-frame: sys_rst asserted at E0+30.
  - Outputs go to reset values in the same cycle: oe=1, no done.
  - After release, a new frame completes normally.
- HC595_PWM_EN, brightness=64, after the first frame: over any 256-cycle window, oe=0 for exactly 64 cycles. brightness=0 keeps oe=1.
